// File: rtl/cb_bus_arbiter.sv
// N-master core-bus arbiter: round-robin grant onto one slave port, in-flight master IDs in a FIFO for in-order response routing.
// Optional build macro CB_ARB_LOCK_EN adds m_lock_i so a master can keep the grant across an atomic sequence.
module cb_bus_arbiter #(
  parameter int NUM_MASTERS     = 2,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_MASTERS-1:0]          m_req_valid_i,
  output logic [NUM_MASTERS-1:0]          m_req_ready_o,
  input  logic [NUM_MASTERS*ADDR_W-1:0]   m_req_addr_i,
  input  logic [NUM_MASTERS-1:0]          m_req_we_i,
  input  logic [NUM_MASTERS*DATA_W-1:0]   m_req_wdata_i,
  input  logic [NUM_MASTERS*DATA_W/8-1:0] m_req_wstrb_i,
`ifdef CB_ARB_LOCK_EN
  input  logic [NUM_MASTERS-1:0]          m_lock_i,
`endif
  output logic [NUM_MASTERS-1:0]          m_resp_valid_o,
  output logic [DATA_W-1:0]               m_resp_rdata_o,
  output logic                            m_resp_error_o,
  output logic                            s_req_valid_o,
  input  logic                            s_req_ready_i,
  output logic [ADDR_W-1:0]               s_req_addr_o,
  output logic                            s_req_we_o,
  output logic [DATA_W-1:0]               s_req_wdata_o,
  output logic [DATA_W/8-1:0]             s_req_wstrb_o,
  input  logic                            s_resp_valid_i,
  input  logic [DATA_W-1:0]               s_resp_rdata_i,
  input  logic                            s_resp_error_i,
  output logic                            s_resp_ready_o,
  output logic                            spurious_resp_o
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int PTR_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int FIFO_D = 2 ** PTR_W;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MASTERS - 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTSTANDING);

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
  endfunction

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
  endfunction

  function automatic logic [NUM_MASTERS-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_MASTERS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // First requester at or after ptr, wrapping modulo NUM_MASTERS.
  function automatic logic [IDX_W-1:0] rr_search(input logic [NUM_MASTERS-1:0] vld,
                                                 input logic [IDX_W-1:0]       ptr);
    logic [IDX_W-1:0] pick;
    logic             found;
    int               j;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_MASTERS) j = j - NUM_MASTERS;
      if (!found && vld[j[IDX_W-1:0]]) begin
        pick  = j[IDX_W-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // Control state (reset) and storage (not reset).
  logic [IDX_W-1:0] rr_ptr;
  logic             hold;
  logic [IDX_W-1:0] hold_idx;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             spur_q;
  logic [IDX_W-1:0] fifo_mem [FIFO_D];
`ifdef CB_ARB_LOCK_EN
  logic             lock_act;
  logic [IDX_W-1:0] lock_idx;
`endif

  logic [IDX_W-1:0] grant;
  logic             gnt_vld;
  logic             full;
  logic             fifo_empty;
  logic             accept;
  logic             pop;

  always_comb begin
    grant = rr_search(m_req_valid_i, rr_ptr);
`ifdef CB_ARB_LOCK_EN
    if (lock_act) grant = lock_idx;
`endif
    if (hold) grant = hold_idx;
  end

  assign gnt_vld    = m_req_valid_i[grant];
  assign full       = (count == FULL_CNT);
  assign fifo_empty = (count == '0);

  // Request path: combinational pass-through of the granted master.
  assign s_req_valid_o = !rst && gnt_vld && !full;
  assign accept        = s_req_valid_o && s_req_ready_i;
  assign m_req_ready_o = (s_req_valid_o && s_req_ready_i) ? onehot(grant) : '0;
  assign s_req_addr_o  = m_req_addr_i[int'(grant)*ADDR_W +: ADDR_W];
  assign s_req_we_o    = m_req_we_i[grant];
  assign s_req_wdata_o = m_req_wdata_i[int'(grant)*DATA_W +: DATA_W];
  assign s_req_wstrb_o = m_req_wstrb_i[int'(grant)*STRB_W +: STRB_W];

  // Response path: route to the oldest in-flight master.
  assign pop             = !rst && s_resp_valid_i && !fifo_empty;
  assign m_resp_valid_o  = pop ? onehot(fifo_mem[rd_ptr]) : '0;
  assign m_resp_rdata_o  = rst ? '0 : s_resp_rdata_i;
  assign m_resp_error_o  = !rst && s_resp_error_i;
  assign s_resp_ready_o  = !rst && !fifo_empty;
  assign spurious_resp_o = !rst && spur_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= '0;
      hold     <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      spur_q   <= 1'b0;
`ifdef CB_ARB_LOCK_EN
      lock_act <= 1'b0;
`endif
    end else begin
      if (accept) begin
        hold   <= 1'b0;
        wr_ptr <= next_ptr(wr_ptr);
`ifdef CB_ARB_LOCK_EN
        lock_act <= m_lock_i[grant];
        if (!m_lock_i[grant]) rr_ptr <= next_idx(grant);
`else
        rr_ptr <= next_idx(grant);
`endif
      end else if (s_req_valid_o) begin
        hold <= 1'b1;
      end
      if (pop) rd_ptr <= next_ptr(rd_ptr);
      if (accept && !pop)      count <= count + CNT_W'(1);
      else if (!accept && pop) count <= count - CNT_W'(1);
      if (s_resp_valid_i && fifo_empty) spur_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) fifo_mem[wr_ptr] <= grant;
    if (s_req_valid_o && !s_req_ready_i) hold_idx <= grant;
`ifdef CB_ARB_LOCK_EN
    if (accept) lock_idx <= grant;
`endif
  end

endmodule

// File: tb/tb_cb_bus_arbiter.sv
// Bench for cb_bus_arbiter: directed scenarios plus randomized traffic checked every cycle against a queue-based model.
module tb_cb_bus_arbiter;
  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int MO = 4;

  logic              clk;
  logic              rst;
  logic [N-1:0]      m_req_valid_i;
  logic [N-1:0]      m_req_ready_o;
  logic [N*AW-1:0]   m_req_addr_i;
  logic [N-1:0]      m_req_we_i;
  logic [N*DW-1:0]   m_req_wdata_i;
  logic [N*SW-1:0]   m_req_wstrb_i;
  logic [N-1:0]      m_lock_i;
  logic [N-1:0]      m_resp_valid_o;
  logic [DW-1:0]     m_resp_rdata_o;
  logic              m_resp_error_o;
  logic              s_req_valid_o;
  logic              s_req_ready_i;
  logic [AW-1:0]     s_req_addr_o;
  logic              s_req_we_o;
  logic [DW-1:0]     s_req_wdata_o;
  logic [SW-1:0]     s_req_wstrb_o;
  logic              s_resp_valid_i;
  logic [DW-1:0]     s_resp_rdata_i;
  logic              s_resp_error_i;
  logic              s_resp_ready_o;
  logic              spurious_resp_o;

  int total = 0;
  int bad   = 0;

  cb_bus_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MO)) dut (
    .clk(clk), .rst(rst),
    .m_req_valid_i(m_req_valid_i), .m_req_ready_o(m_req_ready_o),
    .m_req_addr_i(m_req_addr_i), .m_req_we_i(m_req_we_i),
    .m_req_wdata_i(m_req_wdata_i), .m_req_wstrb_i(m_req_wstrb_i),
`ifdef CB_ARB_LOCK_EN
    .m_lock_i(m_lock_i),
`endif
    .m_resp_valid_o(m_resp_valid_o), .m_resp_rdata_o(m_resp_rdata_o),
    .m_resp_error_o(m_resp_error_o),
    .s_req_valid_o(s_req_valid_o), .s_req_ready_i(s_req_ready_i),
    .s_req_addr_o(s_req_addr_o), .s_req_we_o(s_req_we_o),
    .s_req_wdata_o(s_req_wdata_o), .s_req_wstrb_o(s_req_wstrb_o),
    .s_resp_valid_i(s_resp_valid_i), .s_resp_rdata_i(s_resp_rdata_i),
    .s_resp_error_i(s_resp_error_i), .s_resp_ready_o(s_resp_ready_o),
    .spurious_resp_o(spurious_resp_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: arbitration pointer, held/locked master, queue of in-flight owners.
  int rr_m   = 0;
  int hold_m = -1;
  int lock_m = -1;
  int q_m[$];
  bit spur_m = 1'b0;

  always @(negedge clk) begin : cmp
    int g;
    bit gv, e_sv, is_full;
    logic [N-1:0] e_ready, e_resp;
    if (rst) begin
      check("rst_req_ready", m_req_ready_o, 0);
      check("rst_s_valid", s_req_valid_o, 0);
      check("rst_resp_valid", m_resp_valid_o, 0);
      check("rst_rdata", m_resp_rdata_o, 0);
      check("rst_error", m_resp_error_o, 0);
      check("rst_s_resp_ready", s_resp_ready_o, 0);
      check("rst_spurious", spurious_resp_o, 0);
      rr_m = 0; hold_m = -1; lock_m = -1; spur_m = 1'b0;
      q_m.delete();
    end else begin
      is_full = (q_m.size() == MO);
      g = -1;
      if (hold_m >= 0) g = hold_m;
      else if (lock_m >= 0) g = lock_m;
      else for (int k = 0; k < N; k++) if (g < 0 && m_req_valid_i[(rr_m + k) % N]) g = (rr_m + k) % N;
      gv      = (g >= 0) && m_req_valid_i[g];
      e_sv    = gv && !is_full;
      e_ready = (e_sv && s_req_ready_i) ? (N'(1) << g) : '0;
      check("m_req_ready", m_req_ready_o, e_ready);
      check("s_req_valid", s_req_valid_o, e_sv);
      if (e_sv) begin
        check("s_req_addr", s_req_addr_o, m_req_addr_i[g*AW +: AW]);
        check("s_req_we", s_req_we_o, m_req_we_i[g]);
        check("s_req_wdata", s_req_wdata_o, m_req_wdata_i[g*DW +: DW]);
        check("s_req_wstrb", s_req_wstrb_o, m_req_wstrb_i[g*SW +: SW]);
      end
      e_resp = (s_resp_valid_i && q_m.size() > 0) ? (N'(1) << q_m[0]) : '0;
      check("m_resp_valid", m_resp_valid_o, e_resp);
      check("m_resp_rdata", m_resp_rdata_o, s_resp_rdata_i);
      check("m_resp_error", m_resp_error_o, s_resp_error_i);
      check("s_resp_ready", s_resp_ready_o, q_m.size() > 0);
      check("spurious", spurious_resp_o, spur_m);
      if (s_resp_valid_i) begin
        if (q_m.size() > 0) void'(q_m.pop_front());
        else spur_m = 1'b1;
      end
      if (e_sv && s_req_ready_i) begin
        q_m.push_back(g);
        hold_m = -1;
`ifdef CB_ARB_LOCK_EN
        if (m_lock_i[g]) lock_m = g;
        else begin lock_m = -1; rr_m = (g + 1) % N; end
`else
        rr_m = (g + 1) % N;
`endif
      end else if (e_sv) begin
        hold_m = g;
      end
    end
  end

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    m_req_valid_i = '0; m_req_addr_i = '0; m_req_we_i = '0;
    m_req_wdata_i = '0; m_req_wstrb_i = '0; m_lock_i = '0;
    s_req_ready_i = 1'b0; s_resp_valid_i = 1'b0;
    s_resp_rdata_i = '0; s_resp_error_i = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    nxt();
    smp();
    check("lit_rst_s_valid", s_req_valid_o, 0);
    check("lit_rst_s_resp_ready", s_resp_ready_o, 0);
    nxt();
    rst = 1'b0;
  endtask

  logic [N-1:0] acc;

  initial begin
    rst = 1'b1;
    clear_inputs();
    do_reset();

    // Single master read with pass-through and response routing.
    m_req_valid_i = 2'b01; m_req_addr_i[0 +: AW] = 32'h1000; s_req_ready_i = 1'b1;
    smp();
    check("t1_addr", s_req_addr_o, 32'h1000);
    check("t1_ready", m_req_ready_o, 2'b01);
    nxt();
    m_req_valid_i = '0; s_resp_valid_i = 1'b1; s_resp_rdata_i = 32'hDEADBEEF;
    smp();
    check("t1_resp_valid", m_resp_valid_o, 2'b01);
    check("t1_rdata", m_resp_rdata_o, 32'hDEADBEEF);
    nxt();
    s_resp_valid_i = 1'b0;

    // Alternating grants and responses.
    do_reset();
    m_req_addr_i = {32'h0B0, 32'h0A0}; m_req_valid_i = 2'b11; s_req_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      smp();
      check("t2_grant", m_req_ready_o, (i % 2 == 0) ? 2'b01 : 2'b10);
      check("t2_addr", s_req_addr_o, (i % 2 == 0) ? 32'h0A0 : 32'h0B0);
      nxt();
    end
    m_req_valid_i = '0;
    for (int i = 0; i < 4; i++) begin
      s_resp_valid_i = 1'b1; s_resp_rdata_i = 32'(i);
      smp();
      check("t2_route", m_resp_valid_o, (i % 2 == 0) ? 2'b01 : 2'b10);
      nxt();
    end
    s_resp_valid_i = 1'b0;

    // Held grant survives a higher-priority requester.
    do_reset();
    m_req_valid_i = 2'b01; m_req_addr_i[0 +: AW] = 32'h100; s_req_ready_i = 1'b1;
    nxt();
    m_req_valid_i = '0; s_resp_valid_i = 1'b1;
    nxt();
    s_resp_valid_i = 1'b0;
    m_req_valid_i = 2'b01; m_req_addr_i[0 +: AW] = 32'h200; s_req_ready_i = 1'b0;
    smp(); check("t3_hold_c1", s_req_addr_o, 32'h200);
    nxt();
    m_req_valid_i = 2'b11; m_req_addr_i[AW +: AW] = 32'h300;
    smp(); check("t3_hold_c2", s_req_addr_o, 32'h200);
    check("t3_ready_c2", m_req_ready_o, 2'b00);
    nxt();
    smp(); check("t3_hold_c3", s_req_addr_o, 32'h200);
    nxt();
    s_req_ready_i = 1'b1;
    smp(); check("t3_accept_m0", m_req_ready_o, 2'b01);
    nxt();
    m_req_valid_i = 2'b10;
    smp(); check("t3_then_m1", m_req_ready_o, 2'b10);
    check("t3_m1_addr", s_req_addr_o, 32'h300);
    nxt();
    m_req_valid_i = '0;

    // Outstanding limit: pop does not bypass full.
    do_reset();
    m_req_valid_i = 2'b01; s_req_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      m_req_addr_i[0 +: AW] = 32'h400 + 32'(4 * i);
      smp(); check("t4_fill", m_req_ready_o, 2'b01);
      nxt();
    end
    m_req_addr_i[0 +: AW] = 32'h410;
    smp(); check("t4_full_ready", m_req_ready_o, 2'b00);
    check("t4_full_valid", s_req_valid_o, 0);
    nxt();
    s_resp_valid_i = 1'b1;
    smp(); check("t4_no_bypass", m_req_ready_o, 2'b00);
    check("t4_resp", m_resp_valid_o, 2'b01);
    nxt();
    s_resp_valid_i = 1'b0;
    smp(); check("t4_resume", m_req_ready_o, 2'b01);
    nxt();
    m_req_valid_i = '0;

    // Spurious response is sticky until reset.
    do_reset();
    s_resp_valid_i = 1'b1;
    smp(); check("t5_no_resp", m_resp_valid_o, 2'b00);
    nxt();
    s_resp_valid_i = 1'b0;
    smp(); check("t5_spur_set", spurious_resp_o, 1);
    nxt(); nxt();
    smp(); check("t5_spur_sticky", spurious_resp_o, 1);
    nxt();
    rst = 1'b1;
    smp(); check("t5_spur_rst", spurious_resp_o, 0);
    nxt();
    rst = 1'b0;

`ifdef CB_ARB_LOCK_EN
    // Locked master keeps the grant across its sequence.
    do_reset();
    m_req_valid_i = 2'b01; s_req_ready_i = 1'b1;
    nxt();
    m_req_valid_i = 2'b11; m_lock_i = 2'b10; s_resp_valid_i = 1'b1;
    smp(); check("t6_lock1", m_req_ready_o, 2'b10);
    nxt();
    smp(); check("t6_lock2", m_req_ready_o, 2'b10);
    nxt();
    m_lock_i = 2'b00;
    smp(); check("t6_unlock", m_req_ready_o, 2'b10);
    nxt();
    smp(); check("t6_then_m0", m_req_ready_o, 2'b01);
    nxt();
    m_req_valid_i = '0; s_resp_valid_i = 1'b0;
`endif

    // Randomized traffic; masters hold valid and payload until accepted.
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      smp();
      acc = m_req_valid_i & m_req_ready_o;
      nxt();
      rst = (cyc == 1500 || cyc == 1501);
      for (int i = 0; i < N; i++) begin
        if (!m_req_valid_i[i] || acc[i]) begin
          m_req_valid_i[i] = ($urandom % 100) < 55;
          m_req_addr_i[i*AW +: AW]  = $urandom;
          m_req_we_i[i]             = $urandom % 2;
          m_req_wdata_i[i*DW +: DW] = $urandom;
          m_req_wstrb_i[i*SW +: SW] = SW'($urandom);
          m_lock_i[i]               = ($urandom % 100) < 20;
        end
      end
      s_req_ready_i  = ($urandom % 100) < 70;
      s_resp_valid_i = (q_m.size() > 0) && (($urandom % 100) < 50);
      s_resp_rdata_i = $urandom;
      s_resp_error_i = ($urandom % 8) == 0;
    end
    clear_inputs();
    nxt(); nxt();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cb_bus_arbiter.md
Name: cb_bus_arbiter

Overview:
- Parametrised N-master core-bus arbiter that merges several core-bus masters onto one slave port.
- Typical masters: instruction fetch and LSU of one or more harts.
- Round-robin grant; up to MAX_OUTSTANDING in-flight requests tracked in an ID FIFO so that in-order responses return to the issuing master.
- Sits between the core's bus masters and a single cb_to_axi bridge. Generalises the current fixed one-bridge-per-master top-level wiring.

Parameters:
- NUM_MASTERS, 2, number of master ports (2..8)
- ADDR_W, 32, request address width
- DATA_W, 32, data width; multiple of 8
- MAX_OUTSTANDING, 4, depth of the in-flight ID FIFO (power of 2, >=1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- m_req_valid_i  in  NUM_MASTERS  per-master request valid
- m_req_ready_o  out  NUM_MASTERS  per-master request ready
- m_req_addr_i  in  NUM_MASTERS*ADDR_W  packed addresses; master i at [i*ADDR_W +: ADDR_W]
- m_req_we_i  in  NUM_MASTERS  write enable
- m_req_wdata_i  in  NUM_MASTERS*DATA_W  packed write data
- m_req_wstrb_i  in  NUM_MASTERS*DATA_W/8  packed byte strobes
- m_resp_valid_o  out  NUM_MASTERS  one-hot response valid to the owning master
- m_resp_rdata_o  out  DATA_W  shared response data
- m_resp_error_o  out  1  shared response error
- s_req_valid_o  out  1  slave request valid
- s_req_ready_i  in  1  slave request ready
- s_req_addr_o  out  ADDR_W  granted address
- s_req_we_o  out  1  granted write enable
- s_req_wdata_o  out  DATA_W  granted write data
- s_req_wstrb_o  out  DATA_W/8  granted byte strobes
- s_resp_valid_i  in  1  slave response valid, in request order
- s_resp_rdata_i  in  DATA_W  slave read data
- s_resp_error_i  in  1  slave error
- s_resp_ready_o  out  1  response accept; equals FIFO non-empty
- spurious_resp_o  out  1  sticky flag: response received with FIFO empty

Behaviour:
- Reset: RR pointer = 0, FIFO empty, count = 0, hold flag = 0, spurious_resp_o = 0. All outputs are 0 while rst is high, except s_req_* data fields (don't care).
- Grant (combinational): the first requesting master at or after the RR pointer, searching with wrap-around modulo NUM_MASTERS.
- Full gating: when count == MAX_OUTSTANDING, s_req_valid_o = 0 and all m_req_ready_o = 0. A response pop in the same cycle does not bypass; new accepts resume the next cycle.
- Request path: s_req_valid_o = any request && !full. s_req_* muxes from the granted master. m_req_ready_o[g] = s_req_ready_i && !full; all other ready bits are 0.
- Handshake stability: if s_req_valid_o=1 and s_req_ready_i=0, the hold flag sets and the grant index is registered. The grant stays on that master until acceptance, even if higher-priority masters assert. Masters must hold valid and payload until ready.
- Accept (s_req_valid_o && s_req_ready_i):
  - push the grant index into the FIFO;
  - RR pointer <- (grant+1) mod NUM_MASTERS;
  - hold flag clears.
- Latency: zero-cycle combinational pass-through from master request to slave request.
- Response: when s_resp_valid_i && FIFO non-empty:
  - m_resp_valid_o = onehot(FIFO head); rdata and error pass through combinationally;
  - pop the head.
- Spurious response: s_resp_valid_i with FIFO empty is dropped, no m_resp_valid_o, and spurious_resp_o sets (cleared only by rst).
- Simultaneous push and pop: count unchanged; FIFO pointers wrap modulo MAX_OUTSTANDING.
- Masters always accept responses; there is no master-side response backpressure.
- Reset mid-transaction: FIFO, count and pointers clear immediately. Responses arriving later are treated as spurious.

Optional Feature:
- Macro: CB_ARB_LOCK_EN.
- With the macro: extra port m_lock_i (in, NUM_MASTERS). If the accepted master has m_lock_i[g]=1, the grant stays on g for subsequent requests; the RR pointer does not advance. This continues until g is accepted with m_lock_i[g]=0; RR then advances to g+1. This supports atomic read-modify-write sequences.
- Without the macro: the port is absent and plain round-robin applies.

Test Plan:
- Single master 0, addr 0x1000, read, slave ready=1 -> s_req_addr_o=0x1000 same cycle; slave response rdata 0xDEADBEEF -> m_resp_valid_o=2'b01, rdata 0xDEADBEEF.
- Masters 0 and 1 both requesting continuously, slave always ready, NUM_MASTERS=2 -> grants alternate 0,1,0,1; responses route 01,10,01,10.
- Master 0 requesting, s_req_ready_i=0 for 3 cycles while master 1 also asserts -> s_req_addr_o stays master 0's for all 3 cycles; master 1 is granted only after master 0 is accepted.
- MAX_OUTSTANDING=4, issue 4 requests with no responses -> 5th request sees ready=0. Give one response -> 5th accepted the following cycle, not the same cycle.
- s_resp_valid_i=1 with no outstanding requests -> no m_resp_valid_o, spurious_resp_o=1 until rst.
- CB_ARB_LOCK_EN: master 1 issues 2 locked requests then 1 unlocked while master 0 requests -> order 1,1,1, then 0.
